cen_mean_subtractor: RTL
========================

Name: cen_mean_subtractor

Overview:
- Second half of the whitening centering stage. Takes the four per-channel sums produced by the centering accumulator over N = 2^N_LOG2 samples and derives each channel mean by arithmetic right shift.
- Then accepts the same N samples a second time and outputs each sample minus its channel mean.
- Feeds zero-mean 4-channel data to the covariance/whitening path.

Parameters:
- DATA_W, 16, signed sample width, input and output.
- SUM_W, 21, signed width of the incoming channel sums.
- N_LOG2, 5, log2 of samples per block (N = 32). Requires SUM_W >= DATA_W + N_LOG2.

Ports:
- clk  in  1  rising-edge clock
- En  in  1  synchronous active-low reset; low clears all state on the next clk edge
- sum_valid  in  1  one-cycle strobe; sum1..sum4 are valid
- sum1, sum2, sum3, sum4  in  SUM_W each  signed channel sums
- in_valid  in  1  sample strobe
- in_ready  out  1  high when samples are accepted
- x1_in, x2_in, x3_in, x4_in  in  DATA_W each  signed samples
- out_valid  out  1  centered sample valid
- y1, y2, y3, y4  out  DATA_W each  signed centered samples
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the N-th centered sample is issued

Behaviour:
- Reset (En=0 at clk edge):
  - State goes to IDLE.
  - mean1..4 = 0, sample counter = 0.
  - in_ready = 0, out_valid = 0, y1..4 = 0, busy = 0, done = 0.
  - Reset has priority over every other input. Reset mid-STREAM abandons the block with no done pulse.
- FSM states: IDLE, LOAD, STREAM, DONE.
- IDLE:
  - sum_valid=1 registers the four sums and moves to LOAD.
  - in_valid is ignored.
- LOAD, one cycle:
  - meank = sumk >>> N_LOG2 (arithmetic shift, floor), truncated to DATA_W+1 bits.
  - Counter cleared. Go to STREAM.
- STREAM:
  - in_ready=1.
  - On in_valid=1, for each channel: diff = sign-extended x − mean, computed in DATA_W+2 bits.
  - diff is saturated to [−2^(DATA_W−1), 2^(DATA_W−1)−1] and registered to yk.
  - out_valid=1 on the following cycle, so latency is exactly 1 cycle.
  - out_valid is low in any cycle without an accepted sample. No back-pressure on the output.
  - The counter increments per accepted sample. The sample that makes the count N moves the FSM to DONE, with in_ready low from that edge on.
  - sum_valid is ignored; the stored means stay fixed until the next IDLE.
- DONE, one cycle:
  - done=1. The last out_valid occurs in this same cycle.
  - Return to IDLE.
- Counter:
  - N_LOG2+1 bits. Compares against N; never wraps within a block.
- Simultaneous events:
  - sum_valid in the DONE cycle is ignored. A new block must present sum_valid in IDLE.
  - in_valid in IDLE, LOAD or DONE is dropped with no output.
- Means are computed once per block. The subtraction path is purely registered per sample and adds no bubbles: one sample per cycle is accepted continuously.

Optional Feature:
- Macro CEN_ROUND_EN.
- Defined: meank = (sumk + 2^(N_LOG2−1)) >>> N_LOG2, i.e. round half toward +inf. The addition is done in SUM_W+1 bits so there is no overflow.
- Undefined: plain floor shift as described above.
- All other timing is identical in both builds.

Test Plan:
- Basic: sum1=320, sum2..4=0, then 32 samples with x1=15, others 0 → y1=5, y2..4=0 on every output. Exactly 32 out_valid pulses, out_valid 1 cycle after in_valid, done one cycle after the 32nd acceptance.
- Negative floor/round: sum2=−33 → mean2=−2 without CEN_ROUND_EN (x2=0 → y2=2). With the macro, mean2=−1 (y2=1).
- Saturation: sum3=−1048576 (mean −32768), x3=32767 → y3=32767. Also sum3=+1048544 (mean 32767), x3=−32768 → y3=−32768.
- Gapped input: in_valid toggled 1/0 across 32 samples → out_valid mirrors the pattern with 1-cycle delay. Counter only advances on accepted samples; done after the 32nd.
- Ignored inputs: in_valid in IDLE → no out_valid. sum_valid pulsed mid-STREAM with sum1=640 → outputs still use mean1=10.
- Reset mid-operation: En=0 after 10 samples → next cycle busy=0, out_valid=0, y=0, no done. A fresh sum_valid then completes a full 32-sample block.

Source files
------------

// File: rtl/cen_mean_subtractor.sv
// Mean subtractor for the whitening centering stage.
// Latches four per-channel block sums, derives each channel mean by an arithmetic
// right shift of N_LOG2, then streams N samples out with the mean removed and the
// result saturated to DATA_W bits.
// Build option: define CEN_ROUND_EN to round the mean half toward +inf instead of
// flooring it.
module cen_mean_subtractor #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned SUM_W  = 21,
  parameter int unsigned N_LOG2 = 5
) (
  input  logic                     clk,
  input  logic                     En,
  input  logic                     sum_valid,
  input  logic signed [SUM_W-1:0]  sum1,
  input  logic signed [SUM_W-1:0]  sum2,
  input  logic signed [SUM_W-1:0]  sum3,
  input  logic signed [SUM_W-1:0]  sum4,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] x1_in,
  input  logic signed [DATA_W-1:0] x2_in,
  input  logic signed [DATA_W-1:0] x3_in,
  input  logic signed [DATA_W-1:0] x4_in,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] y1,
  output logic signed [DATA_W-1:0] y2,
  output logic signed [DATA_W-1:0] y3,
  output logic signed [DATA_W-1:0] y4,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned MW = DATA_W + 1;   // mean width
  localparam int unsigned DW = DATA_W + 2;   // difference width, cannot overflow
  localparam int unsigned CW = N_LOG2 + 1;   // counter reaches N without wrapping
  localparam logic [CW-1:0] NCount = CW'(2 ** N_LOG2);
`ifdef CEN_ROUND_EN
  localparam logic signed [SUM_W:0] RoundInc = (SUM_W + 1)'(2 ** (N_LOG2 - 1));
`endif

  typedef enum logic [1:0] {StIdle, StLoad, StStream, StDone} state_e;

  typedef logic signed [SUM_W-1:0]  sum_t;
  typedef logic signed [MW-1:0]     mean_t;
  typedef logic signed [DATA_W-1:0] data_t;

  state_e        state_q, state_d;
  sum_t          sum_q [4];
  sum_t          sum_d [4];
  mean_t         mean_q [4];
  mean_t         mean_d [4];
  data_t         y_q [4];
  data_t         y_d [4];
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d;

  sum_t  sum_in [4];
  data_t x_in [4];

  assign sum_in[0] = sum1;
  assign sum_in[1] = sum2;
  assign sum_in[2] = sum3;
  assign sum_in[3] = sum4;
  assign x_in[0]   = x1_in;
  assign x_in[1]   = x2_in;
  assign x_in[2]   = x3_in;
  assign x_in[3]   = x4_in;

  // Sum is widened by one bit first so the rounding increment cannot overflow.
  function automatic mean_t calc_mean(input sum_t s);
    logic signed [SUM_W:0] ext;
    ext = {s[SUM_W-1], s};
`ifdef CEN_ROUND_EN
    ext = ext + RoundInc;
`endif
    return MW'(ext >>> N_LOG2);
  endfunction

  // x - mean in DW bits, then clamp to the DATA_W signed range.
  function automatic data_t sub_sat(input data_t x, input mean_t m);
    logic [DW-1:0] d;
    d = {{2{x[DATA_W-1]}}, x} - {m[MW-1], m};
    if (d[DW-1:DATA_W-1] != {3{d[DW-1]}}) begin
      return d[DW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
    return d[DATA_W-1:0];
  endfunction

  // Next-state logic for the block FSM and the datapath registers.
  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    mean_d      = mean_q;
    y_d         = y_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sum_valid) begin
          sum_d   = sum_in;
          state_d = StLoad;
        end
      end
      StLoad: begin
        for (int k = 0; k < 4; k++) mean_d[k] = calc_mean(sum_q[k]);
        cnt_d   = '0;
        state_d = StStream;
      end
      StStream: begin
        if (in_valid) begin
          for (int k = 0; k < 4; k++) y_d[k] = sub_sat(x_in[k], mean_q[k]);
          out_valid_d = 1'b1;
          cnt_d       = cnt_q + 1'b1;
          if (cnt_d == NCount) state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!En) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        sum_q[k]  <= '0;
        mean_q[k] <= '0;
        y_q[k]    <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      for (int k = 0; k < 4; k++) begin
        sum_q[k]  <= sum_d[k];
        mean_q[k] <= mean_d[k];
        y_q[k]    <= y_d[k];
      end
    end
  end

  assign in_ready  = (state_q == StStream);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign out_valid = out_valid_q;
  assign y1        = y_q[0];
  assign y2        = y_q[1];
  assign y3        = y_q[2];
  assign y4        = y_q[3];

endmodule
